// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared state encoding, byte width and grant-width helper for tx_frame_arbiter
package tx_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
  function automatic int grant_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester strictly after ptr (wrapping)
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  // Walk from farthest to nearest so the nearest valid requester is written last.
  always_comb begin
    idx = ptr;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin whole-frame arbiter onto one byte port with inter-frame gap and abort.
// Define TX_ARB_STATS_EN to add the stat_frames/stat_errs saturating counters.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN = 1518,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         txd,
  output logic                      tx_en,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      err_underrun,
  output logic                      err_oversize
`ifdef TX_ARB_STATS_EN
  ,
  output logic [31:0]               stat_frames,
  output logic [15:0]               stat_errs
`endif
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  localparam state_t END_ST = IFG_CYCLES == 0 ? IDLE : GAP;

  state_t state, state_n;
  logic [GRANT_W-1:0] rr_ptr, pick;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [BYTE_W-1:0] g_data;
  logic any, g_valid, g_last, rdy, hs, at_max;
  logic underrun_ev, oversize_ev, frame_ok, leave;

  rr_pick #(.N(NUM_REQ), .W(GRANT_W)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .idx(pick),
    .any(any)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last = req_last[grant_id];
  assign g_data = req_data[grant_id*BYTE_W +: BYTE_W];
  assign rdy = state == XFER || state == DRAIN;
  assign req_ready = rdy ? NUM_REQ'(1) << grant_id : '0;
  assign hs = rdy & g_valid;
  // The handshake in flight is byte number MAX_LEN.
  assign at_max = cnt == CW'(MAX_LEN - 1);
  assign busy = state != IDLE;
  assign underrun_ev = state == XFER && !g_valid && |cnt;
  assign oversize_ev = state == XFER && hs && !g_last && at_max;
  assign frame_ok = state == XFER && hs && g_last;
  assign leave = rdy && state_n != state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any ? XFER : IDLE;
      XFER:    state_n = hs ? (g_last ? END_ST : at_max ? DRAIN : XFER) : (|cnt ? DRAIN : XFER);
      DRAIN:   state_n = hs && g_last ? END_ST : DRAIN;
      default: state_n = ~|gap_cnt ? IDLE : GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= GRANT_W'(NUM_REQ - 1);
      grant_id <= '0;
      cnt <= '0;
      gap_cnt <= '0;
      txd <= '0;
      tx_en <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state <= state_n;
      tx_en <= state == XFER && hs;
      err_underrun <= underrun_ev;
      err_oversize <= oversize_ev;
      if (state == XFER && hs) txd <= g_data;
      if (state == IDLE && any) begin
        grant_id <= pick;
        cnt <= '0;
      end else if (state == XFER && hs) begin
        cnt <= cnt + 1'b1;
      end
      if (leave) rr_ptr <= grant_id;
      // Preloaded outside GAP so the gap lasts exactly IFG_CYCLES cycles.
      gap_cnt <= state == GAP ? gap_cnt - 1'b1 : GW'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);
    end
  end

`ifdef TX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errs <= '0;
    end else begin
      if (frame_ok && ~&stat_frames) stat_frames <= stat_frames + 1'b1;
      if ((underrun_ev || oversize_ev) && ~&stat_errs) stat_errs <= stat_errs + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed bench over three builds (default, MAX_LEN=16, IFG_CYCLES=0)
module tb_tx_frame_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid, req_last;
  logic [31:0] req_data;
  logic [3:0] rdy [3];
  logic [7:0] txd [3];
  logic [1:0] gid [3];
  logic tx_en [3], busy [3], eu [3], eo [3];
`ifdef TX_ARB_STATS_EN
  logic [31:0] stat_frames [3];
  logic [15:0] stat_errs [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tx_frame_arbiter #(
      .NUM_REQ(4),
      .IFG_CYCLES(g == 2 ? 0 : 12),
      .MAX_LEN(g == 1 ? 16 : 1518)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_last(req_last),
      .req_ready(rdy[g]),
      .txd(txd[g]),
      .tx_en(tx_en[g]),
      .grant_id(gid[g]),
      .busy(busy[g]),
      .err_underrun(eu[g]),
      .err_oversize(eo[g])
`ifdef TX_ARB_STATS_EN
      ,
      .stat_frames(stat_frames[g]),
      .stat_errs(stat_errs[g])
`endif
    );
  end

  int tests = 0, fails = 0;
  int sel = 0, cyc = 0, t0 = 0, bad = 0, gmin = 0;
  int len [4], pos [4], left [4], drop_at [4], dropn [4];
  logic [7:0] byte_q [$];
  int grant_q [$], run_q [$], gap_q [$];
  int cur_run, zrun, last_tx, busy_fall, first_tx, u_cnt, o_cnt;
  bit seen, prev_en, prev_busy;
  logic [3:0] hs;

  function automatic logic [7:0] dbyte(input int i, input int p);
    return 8'(i * 64 + p);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int bad_bytes(input int src, input int n, input int off);
    int b = 0;
    for (int p = 0; p < n; p++)
      if (off + p >= byte_q.size() || byte_q[off + p] !== dbyte(src, p)) b++;
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (left[i] > 0 && pos[i] == drop_at[i] && dropn[i] > 0) begin
        req_valid[i] = 1'b0;
        dropn[i]--;
      end else begin
        req_valid[i] = left[i] > 0;
      end
      req_data[i*8 +: 8] = dbyte(i, pos[i]);
      req_last[i] = pos[i] == len[i] - 1;
    end
  endtask

  task automatic src(input int i, input int l, input int n, input int da, input int dn);
    len[i] = l;
    left[i] = n;
    pos[i] = 0;
    drop_at[i] = da;
    dropn[i] = dn;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    hs = req_valid & rdy[sel];
    u_cnt += int'(eu[sel]);
    o_cnt += int'(eo[sel]);
    if (tx_en[sel]) begin
      byte_q.push_back(txd[sel]);
      if (!prev_en) begin
        grant_q.push_back(int'(gid[sel]));
        if (seen) gap_q.push_back(zrun);
        zrun = 0;
        if (first_tx < 0) first_tx = cyc;
      end
      cur_run++;
      last_tx = cyc;
      seen = 1;
    end else begin
      if (prev_en) begin
        run_q.push_back(cur_run);
        cur_run = 0;
      end
      zrun++;
    end
    if (prev_busy && !busy[sel]) busy_fall = cyc;
    prev_en = tx_en[sel];
    prev_busy = busy[sel];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin
        if (pos[i] == len[i] - 1) begin
          pos[i] = 0;
          left[i]--;
        end else begin
          pos[i]++;
        end
      end
    drive();
  endtask

  task automatic run(input int n);
    t0 = cyc;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src(i, 1, 0, -1, 0);
    drive();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    byte_q.delete();
    grant_q.delete();
    run_q.delete();
    gap_q.delete();
    cur_run = 0;
    zrun = 0;
    seen = 0;
    prev_en = 0;
    prev_busy = 0;
    first_tx = -1;
    busy_fall = -1;
    last_tx = -1;
    u_cnt = 0;
    o_cnt = 0;
  endtask

  initial begin
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    #1;
    check("rst_tx_en", tx_en[0], 0);
    check("rst_txd", txd[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_grant", gid[0], 0);
    check("rst_ready", rdy[0], 0);
    check("rst_underrun", eu[0], 0);
    check("rst_oversize", eo[0], 0);

    do_reset(0);
    src(0, 64, 1, -1, 0);
    drive();
    run(100);
    check("t1_runs", run_q.size(), 1);
    check("t1_len", run_q[0], 64);
    check("t1_data", bad_bytes(0, 64, 0), 0);
    check("t1_latency", first_tx - t0, 3);
    check("t1_ifg", busy_fall - last_tx, 12);
    check("t1_grant", grant_q[0], 0);
    check("t1_txd_hold", txd[0], dbyte(0, 63));
    check("t1_errs", u_cnt + o_cnt, 0);

    do_reset(0);
    for (int i = 0; i < 4; i++) src(i, 8, 2, -1, 0);
    drive();
    run(250);
    check("t2_frames", grant_q.size(), 8);
    for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), grant_q[k], k % 4);
    gmin = 1000;
    foreach (gap_q[k]) if (gap_q[k] < gmin) gmin = gap_q[k];
    check("t2_gap_cnt", gap_q.size(), 7);
    check("t2_gap_min_ge12", gmin >= 12, 1);
    bad = 0;
    for (int k = 0; k < 8; k++) bad += bad_bytes(k % 4, 8, k * 8);
    check("t2_data", bad, 0);

    do_reset(0);
    src(2, 20, 1, 10, 3);
    src(3, 4, 1, -1, 0);
    drive();
    run(120);
    check("t3_len_first", run_q[0], 10);
    check("t3_len_next", run_q[1], 4);
    check("t3_underrun", u_cnt, 1);
    check("t3_oversize", o_cnt, 0);
    check("t3_grant0", grant_q[0], 2);
    check("t3_grant1", grant_q[1], 3);
    check("t3_drained", left[2], 0);
    check("t3_data", bad_bytes(2, 10, 0) + bad_bytes(3, 4, 10), 0);

    do_reset(1);
    src(0, 20, 1, -1, 0);
    drive();
    run(80);
    check("t4_runs", run_q.size(), 1);
    check("t4_len", run_q[0], 16);
    check("t4_oversize", o_cnt, 1);
    check("t4_underrun", u_cnt, 0);
    check("t4_drained", left[0], 0);
    check("t4_data", bad_bytes(0, 16, 0), 0);
`ifdef TX_ARB_STATS_EN
    check("t4_stat_errs", stat_errs[1], 1);
    check("t4_stat_frames", stat_frames[1], 0);
`endif
    do_reset(1);
    src(0, 16, 1, -1, 0);
    drive();
    run(80);
    check("t4b_len", run_q[0], 16);
    check("t4b_oversize", o_cnt, 0);
    check("t4b_underrun", u_cnt, 0);
    check("t4b_drained", left[0], 0);

    do_reset(2);
    src(1, 5, 1, -1, 0);
    src(3, 5, 1, -1, 0);
    drive();
    run(40);
    check("t5_grant0", grant_q[0], 1);
    check("t5_grant1", grant_q[1], 3);
    check("t5_gap", gap_q[0], 1);
    check("t5_data", bad_bytes(1, 5, 0) + bad_bytes(3, 5, 5), 0);

    do_reset(0);
    src(0, 64, 1, -1, 0);
    drive();
    run(20);
    check("t6_pre_tx_en", tx_en[0], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tx_en", tx_en[0], 0);
    check("t6_txd", txd[0], 0);
    check("t6_busy", busy[0], 0);
    check("t6_ready", rdy[0], 0);
    do_reset(0);
`ifdef TX_ARB_STATS_EN
    check("t6_stat_frames", stat_frames[0], 0);
    check("t6_stat_errs", stat_errs[0], 0);
`endif
    src(0, 4, 1, -1, 0);
    src(1, 4, 1, -1, 0);
    drive();
    run(50);
    check("t6_grant0", grant_q[0], 0);
    check("t6_grant1", grant_q[1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
